input_buffer_arbiter: RTL and testbench

- Shares the single enqueue port of the input buffer among NUM_SRC trace sources.
- Grants are round-robin at frame granularity: a granted source keeps the port until its eof beat, so frames are never interleaved.
- Tracks free buffer slots with credits and only forwards a vector when a credit is available.
- Sits between the trace taps and the input buffer; the source-enable mask is set through the configId/configData bus.

---
 rtl/input_buffer_arbiter.sv | 179 +++++++++++++++++
 tb/tb_input_buffer_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_arbiter.sv
// Frame-granular round-robin arbiter feeding the single input-buffer enqueue port,
// with credit-based flow control and a configurable source-enable mask.
module input_buffer_arbiter #(
  parameter int unsigned        N            = 8,
  parameter int unsigned        DATA_WIDTH   = 32,
  parameter int unsigned        NUM_SRC      = 4,
  parameter int unsigned        IB_DEPTH     = 4,
  parameter int unsigned        CONFIG_ID    = 1,
  parameter logic [NUM_SRC-1:0] INITIAL_MASK = '1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               tracing,
  input  logic [7:0]                         configId,
  input  logic [7:0]                         configData,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC-1:0]                 src_eof,
  input  logic [NUM_SRC*N*DATA_WIDTH-1:0]    src_vector,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic                               credit_return,
  output logic                               enqueue,
  output logic                               eof_out,
  output logic [N*DATA_WIDTH-1:0]            vector_out,
  output logic [$clog2(NUM_SRC)-1:0]         grant_id,
  output logic                               busy,
  output logic                               credit_err
);

  localparam int unsigned VW = N * DATA_WIDTH;
  localparam int unsigned GW = $clog2(NUM_SRC);
  localparam int unsigned CW = $clog2(IB_DEPTH);
  localparam logic [CW-1:0] MaxCredits = CW'(IB_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLocked, StDrain} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic               err_q, err_d;
  logic               busy_q;
  logic               enq_q, eof_q;
  logic [VW-1:0]      vec_q;

  logic [NUM_SRC-1:0] eligible;
  logic               found;
  logic [GW-1:0]      pick;
  int unsigned        idx;
  logic               xfer, xfer_eof;
  logic               cfg_hit;
  logic [NUM_SRC-1:0] cfg_val;
  logic [VW-1:0]      beat_vec;

  assign cfg_hit  = (configId == 8'(CONFIG_ID));
  assign cfg_val  = configData[NUM_SRC-1:0];
  assign beat_vec = src_vector[32'(grant_q)*VW +: VW];

  if (NUM_SRC < 8) begin : g_unused_cfg
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^configData[7:NUM_SRC];
  end

  // First eligible source at or after rr_q, wrapping.
  always_comb begin
    eligible = src_valid & mask_q;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = k + 32'(rr_q);
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && eligible[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    src_ready = '0;
    xfer      = 1'b0;
    xfer_eof  = 1'b0;
    case (state_q)
      StIdle: begin
        if (tracing && found) begin
          grant_d = pick;
          state_d = StLocked;
        end
      end
      StLocked, StDrain: begin
        src_ready[grant_q] = (credits_q != '0);
        xfer               = src_valid[grant_q] && (credits_q != '0);
        xfer_eof           = xfer && src_eof[grant_q];
        if (xfer_eof) begin
          state_d = StIdle;
          rr_d    = (grant_q == GW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        end else if (!tracing) begin
          state_d = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A return at full credit with no transfer is dropped and flagged.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    case ({xfer, credit_return})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == MaxCredits) err_d = 1'b1;
        else                         credits_d = credits_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Mask changes only take effect while no frame is in flight.
  always_comb begin
    mask_d   = mask_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (state_q == StIdle) begin
      if (cfg_hit) mask_d = cfg_val;
    end else if (state_d == StIdle) begin
      if (cfg_hit)       mask_d = cfg_val;
      else if (pend_v_q) mask_d = pend_q;
      pend_v_d = 1'b0;
    end else if (cfg_hit) begin
      pend_d   = cfg_val;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_q      <= '0;
      credits_q <= MaxCredits;
      mask_q    <= INITIAL_MASK;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      enq_q     <= 1'b0;
      eof_q     <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      credits_q <= credits_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      err_q     <= err_d;
      busy_q    <= (state_d != StIdle);
      enq_q     <= xfer;
      eof_q     <= xfer_eof;
      if (xfer) vec_q <= beat_vec;
    end
  end

  assign enqueue    = enq_q;
  assign eof_out    = eof_q;
  assign vector_out = vec_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_input_buffer_arbiter.sv
// Scoreboard bench for input_buffer_arbiter: expected beats are queued as frames are
// scheduled and popped as enqueue pulses appear.
module tb_input_buffer_arbiter;

  localparam int unsigned N   = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned NS  = 4;
  localparam int unsigned IBD = 4;
  localparam int unsigned W   = N * DW;

  typedef struct {
    logic [W-1:0] vec;
    logic         eof;
    int           src;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tracing = 1'b0;
  logic            credit_return = 1'b0;
  logic [7:0]      configId = 8'd0;
  logic [7:0]      configData = 8'd0;
  logic [NS-1:0]   src_valid = '0;
  logic [NS-1:0]   src_eof = '0;
  logic [NS*W-1:0] src_vector = '0;
  logic [NS-1:0]   src_ready;
  logic            enqueue, eof_out, busy, credit_err;
  logic [W-1:0]    vector_out;
  logic [1:0]      grant_id;

  beat_t srcq[NS][$];
  beat_t expq[$];
  int    xfer_cyc[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    enq_count = 0;
  int    mcred = IBD - 1;

  input_buffer_arbiter #(
    .N(N), .DATA_WIDTH(DW), .NUM_SRC(NS), .IB_DEPTH(IBD), .CONFIG_ID(1)
  ) dut (
    .clk(clk), .reset(reset), .tracing(tracing), .configId(configId),
    .configData(configData), .src_valid(src_valid), .src_eof(src_eof),
    .src_vector(src_vector), .src_ready(src_ready), .credit_return(credit_return),
    .enqueue(enqueue), .eof_out(eof_out), .vector_out(vector_out), .grant_id(grant_id),
    .busy(busy), .credit_err(credit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every enqueue must match the next scheduled beat, one cycle after transfer.
  always @(negedge clk) begin
    beat_t e;
    int    c;
    if (!reset && enqueue) begin
      enq_count++;
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_enqueue: got grant_id=%0d eof=%0b, required no enqueue",
                 grant_id, eof_out);
      end else begin
        e = expq.pop_front();
        if (vector_out !== e.vec || eof_out !== e.eof || grant_id !== 2'(e.src)) begin
          miscompares++;
          $display("FAIL beat: got src=%0d eof=%0b vec=%h, required src=%0d eof=%0b vec=%h",
                   grant_id, eof_out, vector_out, e.src, e.eof, e.vec);
        end
      end
      c = (xfer_cyc.size() > 0) ? xfer_cyc.pop_front() : -1;
      vectors++;
      if (c != cyc) begin
        miscompares++;
        $display("FAIL enqueue_latency: got enqueue in cycle %0d, required %0d", cyc, c);
      end
    end
  end

  task automatic add_frame(input int src, input int nb, input bit exp);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      for (int l = 0; l < int'(N); l++) b.vec[l*DW +: DW] = {src[3:0], 4'(i), 24'($urandom)};
      b.eof = (i == nb - 1);
      b.src = src;
      srcq[src].push_back(b);
      if (exp) expq.push_back(b);
    end
  endtask

  // One cycle: present queue heads, then record the handshakes that the next edge takes.
  task automatic step(input logic ret);
    bit xfer;
    @(negedge clk);
    for (int i = 0; i < int'(NS); i++) begin
      if (srcq[i].size() > 0) begin
        src_valid[i]           = 1'b1;
        src_eof[i]             = srcq[i][0].eof;
        src_vector[i*W +: W]   = srcq[i][0].vec;
      end else begin
        src_valid[i] = 1'b0;
        src_eof[i]   = 1'b0;
      end
    end
    credit_return = ret;
    #1;
    vectors++;
    if (!$onehot0(src_ready) || (mcred == 0 && src_ready != '0)) begin
      miscompares++;
      $display("FAIL ready: got src_ready=%b, required one-hot0 and zero at credits=%0d",
               src_ready, mcred);
    end
    xfer = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      if (src_valid[i] && src_ready[i]) begin
        void'(srcq[i].pop_front());
        xfer_cyc.push_back(cyc + 1);
        xfer = 1'b1;
      end
    end
    if (xfer && !ret) mcred--;
    else if (!xfer && ret && mcred < int'(IBD) - 1) mcred++;
  endtask

  task automatic run_drain(input logic ret, input int bound, output bit ok);
    int n = 0;
    while (expq.size() > 0 && n < bound) begin
      step(ret);
      n++;
    end
    ok = (expq.size() == 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    src_valid = '0;
    src_eof = '0;
    credit_return = 1'b0;
    configId = 8'd0;
    tracing = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < int'(NS); i++) srcq[i].delete();
    expq.delete();
    xfer_cyc.delete();
    mcred = IBD - 1;
    enq_count = 0;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if ({enqueue, eof_out, busy, credit_err} !== 4'b0 || vector_out !== '0 ||
        grant_id !== 2'd0 || src_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got enq=%0b eof=%0b busy=%0b err=%0b gid=%0d rdy=%b vec=%h, required all zero",
               enqueue, eof_out, busy, credit_err, grant_id, src_ready, vector_out);
    end
  endtask

  task automatic test_single_frame;
    bit ok;
    do_reset();
    tracing = 1'b1;
    add_frame(2, 3, 1);
    run_drain(1'b0, 20, ok);
    vectors++;
    if (!ok || enq_count != 3) begin
      miscompares++;
      $display("FAIL single_frame_count: got %0d enqueues, required 3", enq_count);
    end
    vectors++;
    if (busy !== 1'b0 || grant_id !== 2'd2) begin
      miscompares++;
      $display("FAIL single_frame_end: got busy=%0b gid=%0d, required busy=0 gid=2", busy, grant_id);
    end
    // rr pointer now 3: source 3 must win over source 2, then source 2 follows.
    add_frame(3, 1, 1);
    add_frame(2, 1, 1);
    run_drain(1'b1, 20, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rr_after_frame: got %0d beats outstanding, required 0", expq.size());
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    do_reset();
    tracing = 1'b1;
    add_frame(0, 2, 1);
    add_frame(1, 2, 1);
    add_frame(0, 2, 1);
    add_frame(1, 2, 1);
    run_drain(1'b1, 40, ok);
    vectors++;
    if (!ok || enq_count != 8) begin
      miscompares++;
      $display("FAIL round_robin: got %0d enqueues, required 8", enq_count);
    end
  endtask

  task automatic test_credits;
    do_reset();
    tracing = 1'b1;
    add_frame(0, 5, 1);
    repeat (8) step(1'b0);
    vectors++;
    if (enq_count != 3 || src_ready !== '0) begin
      miscompares++;
      $display("FAIL credit_stall: got %0d enqueues ready=%b, required 3 and 0000", enq_count, src_ready);
    end
    step(1'b1);
    repeat (4) step(1'b0);
    vectors++;
    if (enq_count != 4 || src_ready !== '0) begin
      miscompares++;
      $display("FAIL credit_single_return: got %0d enqueues ready=%b, required 4 and 0000",
               enq_count, src_ready);
    end
    step(1'b1);
    repeat (3) step(1'b0);
    repeat (6) step(1'b1);
    vectors++;
    if (enq_count != 5 || busy !== 1'b0 || credit_err !== 1'b1) begin
      miscompares++;
      $display("FAIL credit_overflow: got enq=%0d busy=%0b err=%0b, required 5 0 1",
               enq_count, busy, credit_err);
    end
    add_frame(0, 4, 1);
    repeat (10) step(1'b0);
    vectors++;
    if (enq_count != 8 || src_ready !== '0 || credit_err !== 1'b1) begin
      miscompares++;
      $display("FAIL credit_cap: got enq=%0d ready=%b err=%0b, required 8 0000 1",
               enq_count, src_ready, credit_err);
    end
  endtask

  task automatic test_tracing_drop;
    bit ok;
    do_reset();
    tracing = 1'b1;
    add_frame(0, 4, 1);
    add_frame(1, 1, 1);
    repeat (2) step(1'b1);
    tracing = 1'b0;
    step(1'b1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_busy: got busy=%0b, required 1", busy);
    end
    repeat (7) step(1'b1);
    vectors++;
    if (enq_count != 4 || busy !== 1'b0 || src_ready !== '0) begin
      miscompares++;
      $display("FAIL drain_no_grant: got enq=%0d busy=%0b ready=%b, required 4 0 0000",
               enq_count, busy, src_ready);
    end
    tracing = 1'b1;
    run_drain(1'b1, 10, ok);
    vectors++;
    if (!ok || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL drain_regrant: got gid=%0d outstanding=%0d, required 1 and 0", grant_id, expq.size());
    end
  endtask

  task automatic test_config;
    bit ok;
    do_reset();
    tracing = 1'b1;
    add_frame(0, 4, 1);
    add_frame(1, 2, 1);
    add_frame(0, 2, 0);
    repeat (2) step(1'b1);
    configId = 8'd1;
    configData = 8'h02;
    step(1'b1);
    configId = 8'd0;
    run_drain(1'b1, 30, ok);
    repeat (6) step(1'b1);
    vectors++;
    if (!ok || enq_count != 6 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL config_mask: got enq=%0d busy=%0b, required 6 and 0", enq_count, busy);
    end
    configId = 8'd1;
    configData = 8'h00;
    step(1'b1);
    configId = 8'd0;
    add_frame(1, 1, 0);
    repeat (6) step(1'b1);
    vectors++;
    if (enq_count != 6 || busy !== 1'b0 || src_ready !== '0) begin
      miscompares++;
      $display("FAIL zero_mask: got enq=%0d busy=%0b ready=%b, required 6 0 0000",
               enq_count, busy, src_ready);
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    tracing = 1'b1;
    step(1'b1);
    add_frame(0, 4, 1);
    step(1'b0);
    vectors++;
    if (credit_err !== 1'b1) begin
      miscompares++;
      $display("FAIL credit_err_set: got %0b, required 1", credit_err);
    end
    repeat (2) step(1'b0);
    vectors++;
    if (enq_count != 1) begin
      miscompares++;
      $display("FAIL pre_reset_beats: got %0d enqueues, required 1", enq_count);
    end
    do_reset();
    vectors++;
    if ({enqueue, eof_out, busy, credit_err} !== 4'b0 || vector_out !== '0 ||
        grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_frame_reset: got enq=%0b eof=%0b busy=%0b err=%0b gid=%0d, required all zero",
               enqueue, eof_out, busy, credit_err, grant_id);
    end
    tracing = 1'b1;
    add_frame(1, 4, 1);
    repeat (10) step(1'b0);
    vectors++;
    if (enq_count != 3 || src_ready !== '0) begin
      miscompares++;
      $display("FAIL credits_restored: got enq=%0d ready=%b, required 3 and 0000", enq_count, src_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_credits();
    test_tracing_drop();
    test_config();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
